// File: rtl/m_mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encodings,
// requester port identifiers and the read-tracking tag layout.
package m_mem_arbiter_pkg;

    // Halt/drain FSM encodings
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // Requester identifiers
    localparam logic PORT_IF = 1'b0;  // instruction fetch
    localparam logic PORT_DM = 1'b1;  // data load/store

    // One entry of the read-return tracking pipe
    typedef struct packed {
        logic valid;
        logic port;
    } tag_t;

endpackage

// File: rtl/m_mem_arbiter_if.sv
// Bundle of the arbiter's requester, control and RAM-side signals.
// master: pipeline/RAM side, slave: the arbiter itself.
interface m_mem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic          w_req0;
    logic          w_req1;
    logic [AW-1:0] w_addr0;
    logic [AW-1:0] w_addr1;
    logic          w_we0;
    logic          w_we1;
    logic [DW-1:0] w_din0;
    logic [DW-1:0] w_din1;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          r_vld0;
    logic          r_vld1;
    logic [DW-1:0] w_dout0;
    logic [DW-1:0] w_dout1;
    logic          w_halt;
    logic          r_idle;
    logic [AW-1:0] r_maddr;
    logic          r_mwe;
    logic [DW-1:0] r_mdin;
    logic [DW-1:0] w_mdout;

    modport master (
        output w_req0, w_req1, w_addr0, w_addr1, w_we0, w_we1, w_din0, w_din1,
        output w_halt, w_mdout,
        input  w_gnt0, w_gnt1, r_vld0, r_vld1, w_dout0, w_dout1, r_idle,
        input  r_maddr, r_mwe, r_mdin
    );

    modport slave (
        input  w_req0, w_req1, w_addr0, w_addr1, w_we0, w_we1, w_din0, w_din1,
        input  w_halt, w_mdout,
        output w_gnt0, w_gnt1, r_vld0, r_vld1, w_dout0, w_dout1, r_idle,
        output r_maddr, r_mwe, r_mdin
    );
endinterface

// File: rtl/m_mem_arbiter_tagpipe.sv
// m_arb_tagpipe: two-stage {valid,port} shift register that follows each
// granted read through the RAM's address and data register stages, so the
// read-valid strobe lands on the issuing port exactly when RAM data appears.
import m_mem_arbiter_pkg::*;

module m_arb_tagpipe (
    input  logic       w_clk,
    input  logic       w_rst_n,
    input  logic       issue_read,    // a read was granted this cycle
    input  logic       issue_port,    // which port owns that read
    output logic [1:0] vld,           // one-hot read-valid per port
    output logic       pipe_empty,    // no read outstanding anywhere
    output logic       stage1_empty   // pipe will be empty after this edge if nothing issues
);
    tag_t stage1_reg;
    tag_t stage2_reg;

    // Advance tags one stage per cycle; reset drops all in-flight reads
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            stage1_reg <= '0;
            stage2_reg <= '0;
        end else begin
            stage1_reg.valid <= issue_read;
            stage1_reg.port  <= issue_port;
            stage2_reg       <= stage1_reg;
        end
    end

    // Route the last stage to the owning port's valid strobe
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_vld
            assign vld[gi] = stage2_reg.valid && (stage2_reg.port == 1'(gi));
        end
    endgenerate

    assign pipe_empty   = !stage1_reg.valid && !stage2_reg.valid;
    assign stage1_empty = !stage1_reg.valid;

endmodule

// File: rtl/m_mem_arbiter.sv
// m_mem_arbiter: shares one single-port synchronous RAM between the
// instruction-fetch port (0) and the data port (1). At most one grant per
// cycle; read data is routed back to its issuer two cycles after the grant.
// Optional build macro ARB_RR_EN selects round-robin arbitration; without it
// port 1 has fixed priority and port 0 is forced through after MAX_WAIT
// consecutive denied cycles.
import m_mem_arbiter_pkg::*;

module m_mem_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input logic             w_clk,
    input logic             w_rst_n,
    m_mem_arbiter_if.slave  bus
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic [WW-1:0] wait_reg;
    logic          grant_en;
    logic          gnt0;
    logic          gnt1;
    logic          issue_read;
    logic          issue_port;
    logic [1:0]    vld;
    logic          pipe_empty;
    logic          stage1_empty;

`ifdef ARB_RR_EN
    logic          last_reg;
`endif

    // Grants only while running, not halting, and out of reset
    assign grant_en = w_rst_n && (state_reg == ST_RUN) && !bus.w_halt;

    // Arbitrate: a lone request always wins, contention resolved by policy
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (grant_en) begin
            if (bus.w_req0 && bus.w_req1) begin
`ifdef ARB_RR_EN
                gnt0 = (last_reg == PORT_DM);
`else
                gnt0 = (wait_reg == WW'(MAX_WAIT));
`endif
                gnt1 = !gnt0;
            end else begin
                gnt0 = bus.w_req0;
                gnt1 = bus.w_req1;
            end
        end
    end

    assign bus.w_gnt0 = gnt0;
    assign bus.w_gnt1 = gnt1;

    // Register the granted access onto the RAM bus; write strobe drops when idle
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            bus.r_maddr <= '0;
            bus.r_mwe   <= 1'b0;
            bus.r_mdin  <= '0;
        end else if (gnt1) begin
            bus.r_maddr <= bus.w_addr1;
            bus.r_mwe   <= bus.w_we1;
            bus.r_mdin  <= bus.w_din1;
        end else if (gnt0) begin
            bus.r_maddr <= bus.w_addr0;
            bus.r_mwe   <= bus.w_we0;
            bus.r_mdin  <= bus.w_din0;
        end else begin
            bus.r_mwe   <= 1'b0;
        end
    end

`ifdef ARB_RR_EN
    // Round-robin: remember the last winner; starvation is bounded inherently
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            last_reg <= PORT_DM;
            wait_reg <= '0;
        end else begin
            wait_reg <= '0;
            if (gnt0)
                last_reg <= PORT_IF;
            else if (gnt1)
                last_reg <= PORT_DM;
        end
    end
`else
    // Count consecutive denied fetch cycles, saturating at MAX_WAIT
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            wait_reg <= '0;
        end else if (bus.w_req0 && !gnt0) begin
            if (wait_reg != WW'(MAX_WAIT))
                wait_reg <= wait_reg + 1'b1;
        end else begin
            wait_reg <= '0;
        end
    end
`endif

    // Track granted reads so valid returns to the right port two cycles later
    assign issue_read = (gnt0 && !bus.w_we0) || (gnt1 && !bus.w_we1);
    assign issue_port = gnt1 ? PORT_DM : PORT_IF;

    m_arb_tagpipe u_tagpipe (
        .w_clk        (w_clk),
        .w_rst_n      (w_rst_n),
        .issue_read   (issue_read),
        .issue_port   (issue_port),
        .vld          (vld),
        .pipe_empty   (pipe_empty),
        .stage1_empty (stage1_empty)
    );

    assign bus.r_vld0  = vld[0];
    assign bus.r_vld1  = vld[1];
    assign bus.w_dout0 = bus.w_mdout;
    assign bus.w_dout1 = bus.w_mdout;

    // Halt/drain next-state: DRAIN leaves once the last read is in its final stage
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:    if (bus.w_halt) state_next = ST_DRAIN;
            ST_DRAIN:  begin
                if (!bus.w_halt)
                    state_next = ST_RUN;
                else if (stage1_empty)
                    state_next = ST_HALTED;
            end
            ST_HALTED: if (!bus.w_halt) state_next = ST_RUN;
            default:   state_next = ST_RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n)
            state_reg <= ST_RUN;
        else
            state_reg <= state_next;
    end

    assign bus.r_idle = (state_reg == ST_HALTED) && pipe_empty;

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Directed bench for m_mem_arbiter (default fixed-priority build) with a
// behavioural registered-read RAM attached to the arbiter's memory bus.
module tb_m_mem_arbiter;
    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    logic [31:0] mem [0:4095];

    m_mem_arbiter_if #(.AW(12), .DW(32)) bus ();

    m_mem_arbiter #(.AW(12), .DW(32), .MAX_WAIT(4)) dut (
        .w_clk   (clk),
        .w_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM, one-cycle registered read
    always @(posedge clk) begin
        if (bus.r_mwe)
            mem[bus.r_maddr] <= bus.r_mdin;
        bus.w_mdout <= mem[bus.r_maddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic eg0, eg1, ev0, ev1;
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h100 + i * 3;
        bus.w_req0 = 1'b1; bus.w_req1 = 1'b0;
        bus.w_addr0 = '0; bus.w_addr1 = '0;
        bus.w_we0 = 1'b0; bus.w_we1 = 1'b0;
        bus.w_din0 = '0; bus.w_din1 = '0;
        bus.w_halt = 1'b0;
        rst_n = 1'b0;

        // Reset values, grant suppressed even with a request pending
        #12;
        check("rst_gnt0", 32'(bus.w_gnt0), 32'd0);
        check("rst_gnt1", 32'(bus.w_gnt1), 32'd0);
        check("rst_maddr", 32'(bus.r_maddr), 32'd0);
        check("rst_mwe", 32'(bus.r_mwe), 32'd0);
        check("rst_mdin", bus.r_mdin, 32'd0);
        check("rst_vld0", 32'(bus.r_vld0), 32'd0);
        check("rst_vld1", 32'(bus.r_vld1), 32'd0);
        check("rst_idle", 32'(bus.r_idle), 32'd0);
        #6;
        rst_n = 1'b1;
        bus.w_req0 = 1'b0;
        tick();
        tick();

        // Lone read on port 0
        bus.w_req0 = 1'b1; bus.w_addr0 = 12'd5; bus.w_we0 = 1'b0;
        @(negedge clk);
        check("t1_gnt0", 32'(bus.w_gnt0), 32'd1);
        check("t1_gnt1", 32'(bus.w_gnt1), 32'd0);
        tick();
        bus.w_req0 = 1'b0;
        @(negedge clk);
        check("t1_maddr", 32'(bus.r_maddr), 32'd5);
        check("t1_vld0_early", 32'(bus.r_vld0), 32'd0);
        tick();
        @(negedge clk);
        check("t1_vld0", 32'(bus.r_vld0), 32'd1);
        check("t1_dout0", bus.w_dout0, 32'h10f);
        check("t1_vld1", 32'(bus.r_vld1), 32'd0);
        tick();
        @(negedge clk);
        check("t1_vld0_after", 32'(bus.r_vld0), 32'd0);
        tick();

        // Contention: port 0 forced through every fifth cycle
        bus.w_req0 = 1'b1; bus.w_addr0 = 12'd1; bus.w_we0 = 1'b0;
        bus.w_req1 = 1'b1; bus.w_addr1 = 12'd2; bus.w_we1 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 10) begin
                bus.w_req0 = 1'b0;
                bus.w_req1 = 1'b0;
            end
            @(negedge clk);
            eg0 = (k < 10) && (k % 5 == 4);
            eg1 = (k < 10) && !eg0;
            ev0 = (k >= 2) && ((k - 2) % 5 == 4);
            ev1 = (k >= 2) && !ev0;
            check($sformatf("t2_gnt0_k%0d", k), 32'(bus.w_gnt0), 32'(eg0));
            check($sformatf("t2_gnt1_k%0d", k), 32'(bus.w_gnt1), 32'(eg1));
            check($sformatf("t2_vld0_k%0d", k), 32'(bus.r_vld0), 32'(ev0));
            check($sformatf("t2_vld1_k%0d", k), 32'(bus.r_vld1), 32'(ev1));
            if (ev0) check($sformatf("t2_dout0_k%0d", k), bus.w_dout0, 32'h103);
            if (ev1) check($sformatf("t2_dout1_k%0d", k), bus.w_dout1, 32'h106);
            tick();
        end

        // Write on port 1 then read-after-write on port 0
        bus.w_req1 = 1'b1; bus.w_we1 = 1'b1; bus.w_addr1 = 12'd7; bus.w_din1 = 32'hdead;
        @(negedge clk);
        check("t4_gnt1_wr", 32'(bus.w_gnt1), 32'd1);
        tick();
        bus.w_req1 = 1'b0; bus.w_we1 = 1'b0;
        bus.w_req0 = 1'b1; bus.w_addr0 = 12'd7; bus.w_we0 = 1'b0;
        @(negedge clk);
        check("t4_gnt0_rd", 32'(bus.w_gnt0), 32'd1);
        check("t4_mwe", 32'(bus.r_mwe), 32'd1);
        check("t4_maddr", 32'(bus.r_maddr), 32'd7);
        check("t4_mdin", bus.r_mdin, 32'hdead);
        tick();
        bus.w_req0 = 1'b0;
        @(negedge clk);
        check("t4_mwe_off", 32'(bus.r_mwe), 32'd0);
        check("t4_vld1_wr", 32'(bus.r_vld1), 32'd0);
        tick();
        @(negedge clk);
        check("t4_vld0", 32'(bus.r_vld0), 32'd1);
        check("t4_dout0", bus.w_dout0, 32'hdead);
        tick();

        // Halt/drain with a read in flight
        bus.w_req0 = 1'b1; bus.w_addr0 = 12'd9;
        @(negedge clk);
        check("t5_gnt0", 32'(bus.w_gnt0), 32'd1);
        tick();
        bus.w_req1 = 1'b1; bus.w_addr1 = 12'd2; bus.w_halt = 1'b1;
        @(negedge clk);
        check("t5_c1_gnt0", 32'(bus.w_gnt0), 32'd0);
        check("t5_c1_gnt1", 32'(bus.w_gnt1), 32'd0);
        check("t5_c1_idle", 32'(bus.r_idle), 32'd0);
        tick();
        @(negedge clk);
        check("t5_c2_vld0", 32'(bus.r_vld0), 32'd1);
        check("t5_c2_dout0", bus.w_dout0, 32'h11b);
        check("t5_c2_gnt1", 32'(bus.w_gnt1), 32'd0);
        check("t5_c2_idle", 32'(bus.r_idle), 32'd0);
        tick();
        @(negedge clk);
        check("t5_c3_idle", 32'(bus.r_idle), 32'd1);
        check("t5_c3_gnt1", 32'(bus.w_gnt1), 32'd0);
        tick();
        bus.w_halt = 1'b0;
        @(negedge clk);
        check("t5_c4_idle", 32'(bus.r_idle), 32'd1);
        check("t5_c4_gnt0", 32'(bus.w_gnt0), 32'd0);
        tick();
        @(negedge clk);
        check("t5_c5_idle", 32'(bus.r_idle), 32'd0);
        check("t5_c5_gnt0", 32'(bus.w_gnt0), 32'd1);
        check("t5_c5_gnt1", 32'(bus.w_gnt1), 32'd0);
        tick();
        bus.w_req0 = 1'b0; bus.w_req1 = 1'b0;
        @(negedge clk);
        check("t5_c6_vld0", 32'(bus.r_vld0), 32'd0);
        tick();
        @(negedge clk);
        check("t5_c7_vld0", 32'(bus.r_vld0), 32'd1);
        check("t5_c7_dout0", bus.w_dout0, 32'h11b);
        tick();

        // Reset between grant and valid drops the read
        bus.w_req1 = 1'b1; bus.w_addr1 = 12'd3; bus.w_we1 = 1'b0;
        @(negedge clk);
        check("t6_gnt1", 32'(bus.w_gnt1), 32'd1);
        tick();
        bus.w_req1 = 1'b0;
        check("t6_maddr_pre", 32'(bus.r_maddr), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_maddr_rst", 32'(bus.r_maddr), 32'd0);
        check("t6_mwe_rst", 32'(bus.r_mwe), 32'd0);
        check("t6_idle_rst", 32'(bus.r_idle), 32'd0);
        @(negedge clk);
        check("t6_vld1_a", 32'(bus.r_vld1), 32'd0);
        tick();
        @(negedge clk);
        check("t6_vld1_b", 32'(bus.r_vld1), 32'd0);
        rst_n = 1'b1;
        tick();
        bus.w_req0 = 1'b1; bus.w_addr0 = 12'd4;
        @(negedge clk);
        check("t6_gnt0_after", 32'(bus.w_gnt0), 32'd1);
        check("t6_vld1_c", 32'(bus.r_vld1), 32'd0);
        tick();
        bus.w_req0 = 1'b0;
        tick();
        @(negedge clk);
        check("t6_vld0_after", 32'(bus.r_vld0), 32'd1);
        check("t6_dout0_after", bus.w_dout0, 32'h10c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
